// File: rtl/router_pkt_tx_if.sv
// Router input-port bus: staging/command signals in, packet byte stream out.
interface router_pkt_tx_if;
    logic       wr_en;
    logic [7:0] wr_data;
    logic       start;
    logic [1:0] dest;
    logic       corrupt;
    logic       busy;
    logic [7:0] data_out;
    logic       pkt_valid;
    logic       ready;
    logic       pkt_done;
    logic       start_err;

    // Transmitter side
    modport master (
        input  wr_en, wr_data, start, dest, corrupt, busy,
        output data_out, pkt_valid, ready, pkt_done, start_err
    );

    // Harness / router side
    modport slave (
        output wr_en, wr_data, start, dest, corrupt, busy,
        input  data_out, pkt_valid, ready, pkt_done, start_err
    );
endinterface

// File: rtl/router_pkt_tx.sv
// Router packet source: stages up to 63 payload bytes, then sends
// header, payload and parity byte under busy back-pressure.
module router_pkt_tx (
    input  logic            clock,
    input  logic            resetn,
    router_pkt_tx_if.master bus
);
    typedef enum logic [1:0] {StIdle, StHeader, StPayload, StParity} state_e;

    state_e     r_state, w_state_d;
    logic [7:0] r_buf [63];
    logic [5:0] r_count, w_count_d;
    logic [7:0] r_header, w_header_d;
    logic [5:0] r_idx, w_idx_d;
    logic [7:0] r_acc, w_acc_d;
    logic       r_corrupt, w_corrupt_d;
    logic [7:0] r_data_out, w_data_out_d;
    logic       r_pkt_valid, w_pkt_valid_d;
    logic       r_ready, w_ready_d;
    logic       r_pkt_done, w_pkt_done_d;
    logic       r_start_err, w_start_err_d;

    logic       w_start_ok, w_start_bad, w_write, w_adv, w_last;
    logic [5:0] w_len, w_idx_inc;
    logic [7:0] w_cur_byte, w_acc_nxt;

    assign w_len       = r_header[7:2];
    assign w_idx_inc   = r_idx + 6'd1;
    assign w_cur_byte  = r_buf[r_idx];
    assign w_acc_nxt   = r_acc ^ w_cur_byte;
    assign w_last      = (r_idx == (w_len - 6'd1));
    assign w_start_ok  = (r_state == StIdle) && bus.start && (r_count != 6'd0) &&
                         (bus.dest != 2'b11);
    assign w_start_bad = (r_state == StIdle) && bus.start && !w_start_ok;
    // start wins over a simultaneous write; a full buffer ignores writes
    assign w_write     = (r_state == StIdle) && bus.wr_en && !bus.start &&
                         (r_count != 6'd63);
    assign w_adv       = (r_state != StIdle) && !bus.busy;

    assign bus.data_out  = r_data_out;
    assign bus.pkt_valid = r_pkt_valid;
    assign bus.ready     = r_ready;
    assign bus.pkt_done  = r_pkt_done;
    assign bus.start_err = r_start_err;

    // Payload storage; no reset needed, count qualifies the contents
    always_ff @(posedge clock) begin
        if (w_write) begin
            r_buf[r_count] <= bus.wr_data;
        end
    end

    // State and registered outputs
    always_ff @(posedge clock or negedge resetn) begin
        if (!resetn) begin
            r_state     <= StIdle;
            r_count     <= 6'd0;
            r_header    <= 8'h00;
            r_idx       <= 6'd0;
            r_acc       <= 8'h00;
            r_corrupt   <= 1'b0;
            r_data_out  <= 8'h00;
            r_pkt_valid <= 1'b0;
            r_ready     <= 1'b1;
            r_pkt_done  <= 1'b0;
            r_start_err <= 1'b0;
        end else begin
            r_state     <= w_state_d;
            r_count     <= w_count_d;
            r_header    <= w_header_d;
            r_idx       <= w_idx_d;
            r_acc       <= w_acc_d;
            r_corrupt   <= w_corrupt_d;
            r_data_out  <= w_data_out_d;
            r_pkt_valid <= w_pkt_valid_d;
            r_ready     <= w_ready_d;
            r_pkt_done  <= w_pkt_done_d;
            r_start_err <= w_start_err_d;
        end
    end

    // Next-state selection
    always_comb begin
        w_state_d = r_state;
        unique case (r_state)
            StIdle:    if (w_start_ok) w_state_d = StHeader;
            StHeader:  if (w_adv) w_state_d = StPayload;
            StPayload: if (w_adv && w_last) w_state_d = StParity;
            StParity:  if (w_adv) w_state_d = StIdle;
            default:   w_state_d = StIdle;
        endcase
    end

    // Datapath and next output values; everything holds unless advanced
    always_comb begin
        w_count_d     = r_count;
        w_header_d    = r_header;
        w_idx_d       = r_idx;
        w_acc_d       = r_acc;
        w_corrupt_d   = r_corrupt;
        w_data_out_d  = r_data_out;
        w_pkt_valid_d = r_pkt_valid;
        w_ready_d     = r_ready;
        w_pkt_done_d  = 1'b0;
        w_start_err_d = 1'b0;
        unique case (r_state)
            StIdle: begin
                if (w_start_ok) begin
                    w_header_d    = {r_count, bus.dest};
                    w_acc_d       = {r_count, bus.dest};
                    w_corrupt_d   = bus.corrupt;
                    w_data_out_d  = {r_count, bus.dest};
                    w_pkt_valid_d = 1'b1;
                    w_ready_d     = 1'b0;
                end else if (w_start_bad) begin
                    w_start_err_d = 1'b1;
                end else if (w_write) begin
                    w_count_d = r_count + 6'd1;
                end
            end
            StHeader: begin
                if (w_adv) begin
                    w_idx_d      = 6'd0;
                    w_data_out_d = r_buf[0];
                end
            end
            StPayload: begin
                if (w_adv) begin
                    w_acc_d = w_acc_nxt;
                    if (w_last) begin
                        w_data_out_d  = w_acc_nxt ^ {8{r_corrupt}};
                        w_pkt_valid_d = 1'b0;
                    end else begin
                        w_idx_d      = w_idx_inc;
                        w_data_out_d = r_buf[w_idx_inc];
                    end
                end
            end
            StParity: begin
                if (w_adv) begin
                    w_pkt_done_d = 1'b1;
                    w_ready_d    = 1'b1;
                    w_count_d    = 6'd0;
                    w_data_out_d = 8'h00;
                end
            end
            default: ;
        endcase
    end
endmodule

// File: tb/tb_router_pkt_tx.sv
// Self-checking bench for router_pkt_tx against a queue-based packet model.
module tb_router_pkt_tx;
    logic clock = 1'b0;
    logic resetn;

    router_pkt_tx_if bus ();

    router_pkt_tx dut (
        .clock  (clock),
        .resetn (resetn),
        .bus    (bus)
    );

    always #5 clock = ~clock;

    int         n_checks = 0;
    int         n_fail   = 0;
    logic [7:0] mdl_buf [$];
    int         stall_cnt [66];
    logic [7:0] last_header;
    logic [7:0] last_parity;

    task automatic step();
        @(posedge clock);
        #1;
    endtask

    task automatic clear_stalls();
        for (int i = 0; i < 66; i++) stall_cnt[i] = 0;
    endtask

    // Idle write; busy is toggled randomly since it must not matter here
    task automatic write_byte(input logic [7:0] v);
        bus.wr_en   = 1'b1;
        bus.wr_data = v;
        bus.busy    = 1'($urandom_range(0, 1));
        step();
        bus.wr_en = 1'b0;
        if (mdl_buf.size() < 63) mdl_buf.push_back(v);
    endtask

    // Launch the staged packet and follow it byte by byte against the model
    task automatic run_packet(input logic [1:0] d, input logic c, input logic wr_too);
        logic [7:0] exp_data [$];
        logic       exp_valid [$];
        logic [7:0] hdr;
        logic [7:0] par;
        int         len;
        len = mdl_buf.size();
        hdr = {len[5:0], d};
        par = hdr;
        exp_data.push_back(hdr);
        exp_valid.push_back(1'b1);
        foreach (mdl_buf[i]) begin
            exp_data.push_back(mdl_buf[i]);
            exp_valid.push_back(1'b1);
            par = par ^ mdl_buf[i];
        end
        if (c) par = ~par;
        exp_data.push_back(par);
        exp_valid.push_back(1'b0);

        bus.start   = 1'b1;
        bus.dest    = d;
        bus.corrupt = c;
        bus.wr_en   = wr_too;
        bus.wr_data = 8'hA5;
        step();
        bus.start = 1'b0;
        for (int k = 0; k < len + 2; k++) begin
            for (int s = 0; s <= stall_cnt[k]; s++) begin
                bus.busy    = (s < stall_cnt[k]);
                bus.wr_en   = 1'($urandom_range(0, 1));
                bus.corrupt = 1'($urandom_range(0, 1));
                if (k == 0 && s == 0) last_header = bus.data_out;
                if (k == len + 1 && s == 0) last_parity = bus.data_out;
                n_checks++;
                if ({bus.ready, bus.pkt_valid, bus.data_out, bus.pkt_done, bus.start_err} !==
                    {1'b0, exp_valid[k], exp_data[k], 1'b0, 1'b0}) begin
                    n_fail++;
                    $display("FAIL pkt_byte k=%0d s=%0d got rdy=%b v=%b d=%h done=%b err=%b want v=%b d=%h",
                             k, s, bus.ready, bus.pkt_valid, bus.data_out, bus.pkt_done,
                             bus.start_err, exp_valid[k], exp_data[k]);
                end
                step();
            end
        end
        bus.busy  = 1'b0;
        bus.wr_en = 1'b0;
        n_checks++;
        if ({bus.pkt_done, bus.ready, bus.pkt_valid, bus.data_out} !== {1'b1, 1'b1, 1'b0, 8'h00}) begin
            n_fail++;
            $display("FAIL pkt_end got done=%b rdy=%b v=%b d=%h want 1 1 0 00",
                     bus.pkt_done, bus.ready, bus.pkt_valid, bus.data_out);
        end
        mdl_buf.delete();
        step();
        n_checks++;
        if (bus.pkt_done !== 1'b0) begin
            n_fail++;
            $display("FAIL pkt_done_pulse got %b want 0", bus.pkt_done);
        end
    endtask

    task automatic test_reset();
        resetn = 1'b0;
        step();
        step();
        n_checks++;
        if ({bus.ready, bus.pkt_valid, bus.data_out, bus.pkt_done, bus.start_err} !==
            {1'b1, 1'b0, 8'h00, 1'b0, 1'b0}) begin
            n_fail++;
            $display("FAIL reset_state got rdy=%b v=%b d=%h done=%b err=%b want 1 0 00 0 0",
                     bus.ready, bus.pkt_valid, bus.data_out, bus.pkt_done, bus.start_err);
        end
        resetn = 1'b1;
        step();
    endtask

    task automatic test_basic(input logic c, input logic [7:0] want_par);
        clear_stalls();
        write_byte(8'h11);
        write_byte(8'h22);
        write_byte(8'h33);
        run_packet(2'd1, c, 1'b0);
        n_checks++;
        if (last_header !== 8'h0D || last_parity !== want_par) begin
            n_fail++;
            $display("FAIL basic_hdr_par got %h %h want 0d %h", last_header, last_parity, want_par);
        end
    endtask

    task automatic test_back_pressure();
        clear_stalls();
        for (int i = 0; i < 4; i++) write_byte(8'(8'h40 + i));
        stall_cnt[3] = 3;
        stall_cnt[5] = 2;
        run_packet(2'd2, 1'b0, 1'b0);
    endtask

    task automatic test_max_len();
        logic [7:0] want;
        clear_stalls();
        for (int i = 0; i < 64; i++) write_byte(8'(i));
        want = 8'hFE;
        for (int i = 0; i < 63; i++) want = want ^ 8'(i);
        run_packet(2'd2, 1'b0, 1'b0);
        n_checks++;
        if (last_header !== 8'hFE || last_parity !== want) begin
            n_fail++;
            $display("FAIL max_len got hdr=%h par=%h want fe %h", last_header, last_parity, want);
        end
    endtask

    task automatic test_rejects();
        clear_stalls();
        bus.busy  = 1'b0;
        bus.start = 1'b1;
        bus.dest  = 2'd1;
        step();
        bus.start = 1'b0;
        n_checks++;
        if ({bus.start_err, bus.pkt_valid, bus.ready} !== 3'b101) begin
            n_fail++;
            $display("FAIL reject_empty got err=%b v=%b rdy=%b want 1 0 1",
                     bus.start_err, bus.pkt_valid, bus.ready);
        end
        step();
        n_checks++;
        if (bus.start_err !== 1'b0) begin
            n_fail++;
            $display("FAIL reject_pulse got %b want 0", bus.start_err);
        end
        write_byte(8'h81);
        write_byte(8'h82);
        bus.busy  = 1'b0;
        bus.start = 1'b1;
        bus.dest  = 2'd3;
        step();
        bus.start = 1'b0;
        n_checks++;
        if ({bus.start_err, bus.pkt_valid, bus.ready} !== 3'b101) begin
            n_fail++;
            $display("FAIL reject_dest3 got err=%b v=%b rdy=%b want 1 0 1",
                     bus.start_err, bus.pkt_valid, bus.ready);
        end
        run_packet(2'd0, 1'b0, 1'b0);
        n_checks++;
        if (last_header !== 8'h08) begin
            n_fail++;
            $display("FAIL after_reject_hdr got %h want 08", last_header);
        end
        write_byte(8'h91);
        write_byte(8'h92);
        run_packet(2'd1, 1'b0, 1'b1);
        n_checks++;
        if (last_header !== 8'h09) begin
            n_fail++;
            $display("FAIL start_wr_same_cycle got hdr=%h want 09", last_header);
        end
    endtask

    task automatic test_reset_mid_packet();
        clear_stalls();
        for (int i = 0; i < 10; i++) write_byte(8'($urandom));
        bus.busy    = 1'b0;
        bus.start   = 1'b1;
        bus.dest    = 2'd1;
        bus.corrupt = 1'b0;
        step();
        bus.start = 1'b0;
        repeat (6) step();
        n_checks++;
        if (bus.data_out !== mdl_buf[5] || bus.pkt_valid !== 1'b1) begin
            n_fail++;
            $display("FAIL mid_byte5 got d=%h v=%b want %h 1", bus.data_out, bus.pkt_valid, mdl_buf[5]);
        end
        #2;
        resetn = 1'b0;
        #1;
        n_checks++;
        if ({bus.pkt_valid, bus.data_out, bus.ready} !== {1'b0, 8'h00, 1'b1}) begin
            n_fail++;
            $display("FAIL async_reset got v=%b d=%h rdy=%b want 0 00 1",
                     bus.pkt_valid, bus.data_out, bus.ready);
        end
        step();
        resetn = 1'b1;
        mdl_buf.delete();
        step();
        write_byte(8'h5A);
        run_packet(2'd0, 1'b0, 1'b0);
        n_checks++;
        if (last_header !== 8'h04 || last_parity !== 8'h5E) begin
            n_fail++;
            $display("FAIL after_reset_pkt got hdr=%h par=%h want 04 5e", last_header, last_parity);
        end
    endtask

    task automatic test_random();
        int n;
        for (int p = 0; p < 8; p++) begin
            clear_stalls();
            n = $urandom_range(1, 63);
            for (int i = 0; i < n; i++) write_byte(8'($urandom));
            for (int k = 0; k < n + 2; k++) begin
                if ($urandom_range(0, 3) == 0) stall_cnt[k] = $urandom_range(1, 3);
            end
            run_packet(2'($urandom_range(0, 2)), 1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)));
        end
    endtask

    initial begin
        resetn      = 1'b0;
        bus.wr_en   = 1'b0;
        bus.wr_data = 8'h00;
        bus.start   = 1'b0;
        bus.dest    = 2'd0;
        bus.corrupt = 1'b0;
        bus.busy    = 1'b0;
        test_reset();
        test_basic(1'b0, 8'h0D);
        test_basic(1'b1, 8'hF2);
        test_back_pressure();
        test_max_len();
        test_rejects();
        test_reset_mid_packet();
        test_random();
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end
endmodule
